// File: rtl/pkg_slice.sv
// Shared types and constants for the slice_capture acquisition front end.
//   trig_t    : trigger mode selector (none / rising / falling / any edge)
//   state_t   : capture FSM states
//   N_SAMPLES : depth of the sample buffer and width of the published trace
package pkg_slice;

  localparam int unsigned N_SAMPLES = 960;
  localparam int unsigned IDX_W     = 10;

  typedef enum logic [1:0] {
    TRIG_NONE,
    TRIG_RISE,
    TRIG_FALL,
    TRIG_ANY
  } trig_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPT,
    HOLD
  } state_t;

endpackage

// File: rtl/slice_capture_if.sv
// Control/data bundle between the acquisition front end and its environment.
//   din        : asynchronous probe input
//   scan_data  : decimation, sample period = scan_data+1 clocks
//   np         : points to capture (0 or >N_SAMPLES means N_SAMPLES)
//   trig       : trigger mode
//   arm        : start-capture pulse
//   cont       : auto re-arm after publish
//   stop       : abort to IDLE
//   frame_end  : end-of-visible-frame pulse, publish point
//   ch         : published trace, index 0 = trigger sample
//   busy       : capture in progress (ARMED, CAPT, HOLD)
//   done       : one-clock pulse on the publish cycle
interface slice_capture_if;
  import pkg_slice::*;

  logic                 din;
  logic [IDX_W-1:0]     scan_data;
  logic [IDX_W-1:0]     np;
  trig_t                trig;
  logic                 arm;
  logic                 cont;
  logic                 stop;
  logic                 frame_end;
  logic [N_SAMPLES-1:0] ch;
  logic                 busy;
  logic                 done;

  modport master (
    output din, scan_data, np, trig, arm, cont, stop, frame_end,
    input  ch, busy, done
  );

  modport slave (
    input  din, scan_data, np, trig, arm, cont, stop, frame_end,
    output ch, busy, done
  );

endinterface

// File: rtl/slice_sync.sv
// Probe synchronizer: two flops to resolve metastability plus one history flop
// for edge detection.
//   clk_pix : pixel clock
//   rst_n   : synchronous active-low reset
//   i_din   : asynchronous probe input
//   o_level : synchronized level (s2)
//   o_rise  : s2 & !s3
//   o_fall  : !s2 & s3
module slice_sync (
  input  logic clk_pix,
  input  logic rst_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/slice_capture.sv
// Acquisition front end: synchronizes the probe, waits for a trigger, fills a
// shadow buffer with decimated samples and publishes it as ch[] on frame_end,
// so the renderer never sees a half-written trace.
//   clk_pix : pixel clock, the only clock
//   rst_n   : synchronous active-low reset
//   bus     : slave side of slice_capture_if (config, control, ch/busy/done)
module slice_capture
  import pkg_slice::*;
#(
  parameter int unsigned N_SAMPLES = pkg_slice::N_SAMPLES
) (
  input logic            clk_pix,
  input logic            rst_n,
  slice_capture_if.slave bus
);

  localparam logic [IDX_W-1:0] NMax = IDX_W'(N_SAMPLES);

  logic w_level;
  logic w_rise;
  logic w_fall;

  slice_sync u_sync (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .i_din   (bus.din),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_t               r_state, w_state_d;
  logic [IDX_W-1:0]     r_idx, w_idx_d;
  logic [IDX_W-1:0]     r_div, w_div_d;
  logic [IDX_W-1:0]     r_np_l, w_np_l_d;
  logic [IDX_W-1:0]     r_div_l, w_div_l_d;
  logic [N_SAMPLES-1:0] r_shadow;
  logic [N_SAMPLES-1:0] r_ch;
  logic [N_SAMPLES-1:0] w_ch_pub;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_trig_hit;
  logic [IDX_W-1:0]     w_np_clamped;
  logic                 w_latch;
  logic                 w_publish;
  logic                 w_wr_en;
  logic [IDX_W-1:0]     w_wr_idx;

  assign w_np_clamped = (bus.np == '0 || bus.np > NMax) ? NMax : bus.np;

  always_comb begin
    w_trig_hit = 1'b0;
    case (bus.trig)
      TRIG_NONE: w_trig_hit = 1'b1;
      TRIG_RISE: w_trig_hit = w_rise;
      TRIG_FALL: w_trig_hit = w_fall;
      TRIG_ANY:  w_trig_hit = w_rise | w_fall;
      default:   w_trig_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_div_d   = r_div;
    w_np_l_d  = r_np_l;
    w_div_l_d = r_div_l;
    w_latch   = 1'b0;
    w_publish = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_idx;

    unique case (r_state)
      IDLE: begin
        if (bus.arm) begin
          w_state_d = ARMED;
          w_latch   = 1'b1;
        end
      end
      ARMED: begin
        if (w_trig_hit) begin
          w_wr_en   = 1'b1;
          w_wr_idx  = '0;
          w_idx_d   = IDX_W'(1);
          w_div_d   = '0;
          w_state_d = (r_np_l == IDX_W'(1)) ? HOLD : CAPT;
        end
      end
      CAPT: begin
        if (r_div == r_div_l) begin
          w_wr_en  = 1'b1;
          w_wr_idx = r_idx;
          w_idx_d  = r_idx + IDX_W'(1);
          w_div_d  = '0;
          if (r_idx == r_np_l - IDX_W'(1)) begin
            w_state_d = HOLD;
          end
        end else begin
          w_div_d = r_div + IDX_W'(1);
        end
      end
      HOLD: begin
        if (bus.frame_end) begin
          w_publish = 1'b1;
          w_state_d = bus.cont ? ARMED : IDLE;
          w_latch   = bus.cont;
        end
      end
      default: w_state_d = IDLE;
    endcase

    // stop wins over every other event, including a same-cycle publish
    if (bus.stop) begin
      w_state_d = IDLE;
      w_latch   = 1'b0;
      w_publish = 1'b0;
      w_wr_en   = 1'b0;
    end

    if (w_latch) begin
      w_np_l_d  = w_np_clamped;
      w_div_l_d = bus.scan_data;
    end
  end

  // Stale shadow bits beyond np_l are hidden here rather than cleared
  always_comb begin
    w_ch_pub = '0;
    for (int i = 0; i < int'(N_SAMPLES); i++) begin
      w_ch_pub[i] = r_shadow[i] & (IDX_W'(i) < r_np_l);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_div   <= '0;
      r_np_l  <= '0;
      r_div_l <= '0;
      r_ch    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_div   <= w_div_d;
      r_np_l  <= w_np_l_d;
      r_div_l <= w_div_l_d;
      r_busy  <= (w_state_d != IDLE);
      r_done  <= w_publish;
      if (w_publish) begin
        r_ch <= w_ch_pub;
      end
    end
  end

  // Shadow has no reset: its contents only matter up to np_l after a capture
  always_ff @(posedge clk_pix) begin
    if (w_wr_en) begin
      r_shadow[w_wr_idx] <= w_level;
    end
  end

  assign bus.ch   = r_ch;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_slice_capture.sv
module tb_slice_capture;
  import pkg_slice::*;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  slice_capture_if u_if ();

  slice_capture u_dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .bus     (u_if)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_arm();
    u_if.arm = 1'b1;
    tick();
    u_if.arm = 1'b0;
  endtask

  task automatic pulse_frame_end();
    u_if.frame_end = 1'b1;
    tick();
    u_if.frame_end = 1'b0;
  endtask

  logic [8:0] pat;
  int         cnt;

  initial begin
    u_if.din       = 1'b0;
    u_if.scan_data = '0;
    u_if.np        = '0;
    u_if.trig      = TRIG_NONE;
    u_if.arm       = 1'b0;
    u_if.cont      = 1'b0;
    u_if.stop      = 1'b0;
    u_if.frame_end = 1'b0;

    // Reset state
    tick_n(3);
    check("rst_ch", $countones(u_if.ch), 0);
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_done", 32'(u_if.done), 0);
    rst_n = 1'b1;
    tick();

    // Rising trigger, np=8, no decimation; din sequence indexed from bit 0
    pat            = 9'b110010110;
    u_if.trig      = TRIG_RISE;
    u_if.np        = 10'd8;
    u_if.scan_data = 10'd0;
    tick_n(3);
    pulse_arm();
    check("rise_busy", 32'(u_if.busy), 1);
    for (int i = 0; i < 9; i++) begin
      u_if.din = pat[i];
      tick();
    end
    tick_n(10);
    check("rise_prepub_done", 32'(u_if.done), 0);
    check("rise_prepub_ch", u_if.ch[31:0], 32'h0);
    pulse_frame_end();
    check("rise_done", 32'(u_if.done), 1);
    check("rise_ch", u_if.ch[31:0], 32'h0000_00cb);
    check("rise_ones", $countones(u_if.ch), 5);
    check("rise_busy_off", 32'(u_if.busy), 0);
    tick();
    check("rise_done_pulse", 32'(u_if.done), 0);

    // Decimation: scan_data=3, np=4, din toggles every clock, frame_end held
    // high from the trigger edge; capture needs 12 clocks then HOLD.
    u_if.trig      = TRIG_NONE;
    u_if.np        = 10'd4;
    u_if.scan_data = 10'd3;
    cnt            = 0;
    for (int k = -3; k <= 15; k++) begin
      u_if.din       = k[0];
      u_if.arm       = (k == 0);
      u_if.frame_end = (k >= 1);
      tick();
      if (k >= 1 && k <= 13 && u_if.done) cnt++;
      if (k == 14) check("dec_done", 32'(u_if.done), 1);
      if (k == 15) begin
        check("dec_done_once", 32'(u_if.done), 0);
        check("dec_busy_off", 32'(u_if.busy), 0);
      end
    end
    u_if.frame_end = 1'b0;
    u_if.arm       = 1'b0;
    check("dec_early_done", cnt, 0);
    check("dec_ch", u_if.ch[31:0], 32'h0000_000f);

    // Clamp np=0 -> 960 samples of constant 1
    u_if.din       = 1'b1;
    u_if.np        = 10'd0;
    u_if.scan_data = 10'd0;
    tick_n(3);
    pulse_arm();
    tick_n(965);
    pulse_frame_end();
    check("np0_done", 32'(u_if.done), 1);
    check("np0_ones", $countones(u_if.ch), 960);

    // np=1: HOLD on the trigger cycle, only ch[0] may be set
    u_if.np = 10'd1;
    pulse_arm();
    u_if.frame_end = 1'b1;
    tick();
    check("np1_early", 32'(u_if.done), 0);
    tick();
    u_if.frame_end = 1'b0;
    check("np1_done", 32'(u_if.done), 1);
    check("np1_ch", u_if.ch[31:0], 32'h1);
    check("np1_ones", $countones(u_if.ch), 1);

    // stop together with frame_end in HOLD
    u_if.din = 1'b0;
    u_if.np  = 10'd3;
    tick_n(3);
    pulse_arm();
    tick_n(8);
    check("stop_busy_pre", 32'(u_if.busy), 1);
    u_if.stop      = 1'b1;
    u_if.frame_end = 1'b1;
    tick();
    u_if.stop      = 1'b0;
    u_if.frame_end = 1'b0;
    check("stop_done", 32'(u_if.done), 0);
    check("stop_busy", 32'(u_if.busy), 0);
    check("stop_ch", u_if.ch[31:0], 32'h1);
    check("stop_state", 32'(u_dut.r_state), 32'(IDLE));
    pulse_frame_end();
    check("stop_fe_idle", 32'(u_if.done), 0);

    // Clamp np=1000 -> 960 samples of constant 0
    u_if.np = 10'd1000;
    pulse_arm();
    tick_n(965);
    pulse_frame_end();
    check("np1000_done", 32'(u_if.done), 1);
    check("np1000_ones", $countones(u_if.ch), 0);

    // Continuous mode: np re-latched on publish, arm during CAPT ignored
    u_if.cont = 1'b1;
    u_if.np   = 10'd4;
    u_if.din  = 1'b1;
    tick_n(3);
    pulse_arm();
    tick_n(6);
    u_if.np = 10'd5;
    pulse_frame_end();
    check("cont_done1", 32'(u_if.done), 1);
    check("cont_ch1", u_if.ch[31:0], 32'h0000_000f);
    check("cont_busy", 32'(u_if.busy), 1);
    tick();
    u_if.np = 10'd7;
    pulse_arm();
    check("cont_busy_capt", 32'(u_if.busy), 1);
    tick_n(6);
    u_if.cont = 1'b0;
    pulse_frame_end();
    check("cont_done2", 32'(u_if.done), 1);
    check("cont_ch2", u_if.ch[31:0], 32'h0000_001f);
    check("cont_busy_off", 32'(u_if.busy), 0);

    // Reset for one clock in the middle of a capture
    u_if.np = 10'd100;
    pulse_arm();
    tick_n(10);
    check("mrst_busy_pre", 32'(u_if.busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_ch", $countones(u_if.ch), 0);
    check("mrst_busy", 32'(u_if.busy), 0);
    check("mrst_done", 32'(u_if.done), 0);
    check("mrst_state", 32'(u_dut.r_state), 32'(IDLE));
    cnt            = 0;
    u_if.frame_end = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (u_if.done) cnt++;
    end
    u_if.frame_end = 1'b0;
    check("mrst_no_done", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
